// File: rtl/pc_next_unit_pkg.sv
// Shared definitions for the PC / next-PC unit: FSM state encoding,
// the sequential fetch increment, default reset and exception addresses,
// and a word-alignment helper.
package pc_next_unit_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } pc_state_e;

    localparam logic [31:0] PC_INC         = 32'd4;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

    // Force the two low address bits to zero so every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_gen.sv
// Combinational redirect target formation and priority selection.
// Branch target = branch_pc4 + branch_off_sh; jump target = {pc4[31:28], idx, 00}.
// Priority is exc > branch_taken > jump when PC_EXCEPTION_EN is defined,
// otherwise branch_taken > jump and no exc input exists.
module pc_target_gen
    import pc_next_unit_pkg::*;
#(
`ifdef PC_EXCEPTION_EN
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
`endif
) (
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_off_sh,
    input  logic [31:0] i_branch_pc4,
    input  logic        i_jump,
    input  logic [25:0] i_jump_idx,
`ifdef PC_EXCEPTION_EN
    input  logic        i_exc,
`endif
    output logic        o_req,
    output logic [31:0] o_tgt
);

    logic [31:0] w_br_tgt;
    logic [31:0] w_jmp_tgt;

    assign w_br_tgt  = align_word(i_branch_pc4 + i_branch_off_sh);
    assign w_jmp_tgt = {i_branch_pc4[31:28], i_jump_idx, 2'b00};

    // Priority mux: highest-priority active request picks the target.
    always_comb begin
        o_req = 1'b0;
        o_tgt = '0;
`ifdef PC_EXCEPTION_EN
        if (i_exc) begin
            o_req = 1'b1;
            o_tgt = align_word(EXC_VECTOR);
        end else
`endif
        if (i_branch_taken) begin
            o_req = 1'b1;
            o_tgt = w_br_tgt;
        end else if (i_jump) begin
            o_req = 1'b1;
            o_tgt = w_jmp_tgt;
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC selection.
// A redirect that arrives while fetch is stalled is parked in r_pend_tgt
// (state HOLD) and applied on the first unstalled cycle; later branch/jump
// requests during HOLD are dropped so the older redirect wins.
// Optional macro PC_EXCEPTION_EN adds the exc input: it loads EXC_VECTOR
// on the next edge regardless of stall or state and discards any pending redirect.
// Handshake: there is no valid/ready pair; stall=1 means the fetch stage will not
// accept a new address this cycle, and redirects are single-cycle pulses that
// must not be lost, hence the HOLD buffer.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC
`ifdef PC_EXCEPTION_EN
   ,parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_off_sh,
    input  logic [31:0] branch_pc4,
    input  logic        jump,
    input  logic [25:0] jump_idx,
`ifdef PC_EXCEPTION_EN
    input  logic        exc,
`endif
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect_pending,
    output logic [0:0]  o_dbg_state
);

    localparam logic [0:0] S_RUN  = ST_RUN;
    localparam logic [0:0] S_HOLD = ST_HOLD;

    logic [31:0] r_pc;
    logic [31:0] r_pend_tgt;
    logic        r_pending;
    logic [0:0]  r_state;

    logic        w_req;
    logic [31:0] w_tgt;
    logic [31:0] w_pc_plus4;
    logic        w_exc;

    pc_target_gen
`ifdef PC_EXCEPTION_EN
        #(.EXC_VECTOR(EXC_VECTOR))
`endif
    u_tgt (
        .i_branch_taken  (branch_taken),
        .i_branch_off_sh (branch_off_sh),
        .i_branch_pc4    (branch_pc4),
        .i_jump          (jump),
        .i_jump_idx      (jump_idx),
`ifdef PC_EXCEPTION_EN
        .i_exc           (exc),
`endif
        .o_req           (w_req),
        .o_tgt           (w_tgt)
    );

`ifdef PC_EXCEPTION_EN
    assign w_exc = exc;
`else
    assign w_exc = 1'b0;
`endif

    // Wraps naturally from 32'hFFFF_FFFC to 0.
    assign w_pc_plus4 = r_pc + PC_INC;

    // PC register, parked redirect target and RUN/HOLD state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= align_word(RESET_PC);
            r_pend_tgt <= '0;
            r_pending  <= 1'b0;
            r_state    <= S_RUN;
        end else if (w_exc) begin
            // Exception bypasses stall and drops whatever was parked.
            r_pc       <= w_tgt;
            r_pend_tgt <= w_tgt;
            r_pending  <= 1'b0;
            r_state    <= S_RUN;
        end else if (r_state == S_RUN) begin
            if (!stall) begin
                r_pc <= w_req ? w_tgt : w_pc_plus4;
            end else if (w_req) begin
                r_pend_tgt <= w_tgt;
                r_pending  <= 1'b1;
                r_state    <= S_HOLD;
            end
        end else begin
            // HOLD: new branch/jump requests are ignored; release applies the parked target.
            if (!stall) begin
                r_pc      <= r_pend_tgt;
                r_pending <= 1'b0;
                r_state   <= S_RUN;
            end
        end
    end

    assign pc               = r_pc;
    assign pc_plus4         = w_pc_plus4;
    assign redirect_pending = r_pending;
    assign o_dbg_state      = r_state;

endmodule
